usb_tx_sched: RTL and testbench
===============================

Name: usb_tx_sched

Overview:
- Scheduler/controller in front of the USB TX datapath (control FSM, 8-bit shift register, encoder, byte timer).
- Arbitrates between two requesters:
  - the RX-side handshake responder (ACK/NAK/STALL)
  - the AHB-side data-packet requester (DATA0/DATA1)
- Issues one `tx_packet` command at a time and tracks the transfer through `tx_transfer_active` / `tx_error`.
- Maintains the data toggle and reports completion or error per packet.

Parameters:
- START_TIMEOUT, 16, cycles allowed between command issue and `tx_transfer_active` rising before error
- MAX_LEN, 64, maximum data payload bytes (buffer depth)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- hs_req  in  1  handshake request, level, held until hs_grant
- hs_pid  in  2  handshake type: 0=ACK, 1=NAK, 2=STALL, 3=reserved
- hs_grant  out  1  one-cycle pulse, handshake accepted
- data_req  in  1  data packet request, level, held until data_grant
- data_len  in  7  payload byte count, stable while data_req high
- data_grant  out  1  one-cycle pulse, data request accepted
- buffer_occupancy  in  7  bytes currently in TX buffer
- toggle_clr  in  1  pulse, forces data toggle to DATA0
- tx_packet  out  4  command to TX datapath: 0=idle, 1=DATA0, 2=DATA1, 3=ACK, 4=NAK, 5=STALL
- tx_transfer_active  in  1  TX datapath busy
- tx_error  in  1  TX datapath error flag
- busy  out  1  scheduler not in IDLE
- done  out  1  one-cycle pulse, packet sent cleanly
- err  out  1  one-cycle pulse, packet failed or rejected
- data_toggle  out  1  current toggle (0=DATA0 next)

Behaviour:
- Reset values: tx_packet=0, hs_grant=0, data_grant=0, busy=0, done=0, err=0, data_toggle=0, fair flag=0, FSM=IDLE. All outputs are registered.
- Reset mid-transfer: returns immediately to IDLE with the reset values above. The TX datapath is not signalled; its own reset is shared.

States:
- IDLE → ISSUE when a request is eligible.
  - hs_req is always eligible. hs_pid=3 is treated as NAK.
  - data_req is eligible iff buffer_occupancy >= data_len. data_len=0 (zero-length packet) is always eligible.
  - data_len > MAX_LEN: in IDLE, pulse data_grant and err together; no command is issued and the FSM stays in IDLE.
- Arbitration: handshake has priority, except that the fair flag gives data one win.
  - Fair flag sets when hs wins while data_req is eligible.
  - When the flag is set and both requesters are eligible, data wins and the flag clears.
- Grant pulse is registered in the cycle the FSM enters ISSUE. The requester drops its req the following cycle.
- ISSUE (1 cycle): drive tx_packet with the selected code. Data code = DATA0 if data_toggle=0, else DATA1. Then go to WAIT_START with tx_packet back to 0.
- WAIT_START: count cycles.
  - tx_transfer_active=1 → ACTIVE.
  - Count reaches START_TIMEOUT → err pulse, IDLE.
- ACTIVE:
  - Any cycle with tx_error=1 latches a sticky error.
  - On tx_transfer_active falling (1→0): go to DONE.
- DONE (1 cycle):
  - Sticky error set: err pulse.
  - Otherwise: done pulse. If the packet was data, data_toggle inverts.
  - Then clear sticky, go to IDLE.
- Command-to-command spacing: at least 2 idle cycles on tx_packet (DONE, IDLE).
- toggle_clr:
  - In any state, clears data_toggle next cycle.
  - If it coincides with a DONE toggle, clear wins.
- busy = (state != IDLE).
- Latency: request asserted in IDLE → tx_packet nonzero 2 cycles later (grant registered, then ISSUE drives command).

Decomposition:
- Package usb_tx_pkg holds:
  - tx_packet code localparams (TXP_IDLE, TXP_DATA0, TXP_DATA1, TXP_ACK, TXP_NAK, TXP_STALL)
  - handshake pid encodings
  - FSM state enum (IDLE, ISSUE, WAIT_START, ACTIVE, DONE)
- One sub-module: usb_tx_arb. It is combinational eligibility checking plus the registered fair flag, and outputs a select (none/hs/data).
- The FSM, timeout counter and toggle live in the top level.

Test Plan:
- Data request, both PIDs:
  - Stimulus: data_req with data_len=8, buffer_occupancy=8, toggle=0; TX model raises active 3 cycles after command and holds it 40 cycles.
  - Required: data_grant pulse; tx_packet=1 for exactly 1 cycle; done pulse; data_toggle=1.
  - Repeat the request: tx_packet=2.
- Simultaneous requests:
  - Stimulus: hs_req (ACK) and eligible data_req together; hs_req is reasserted immediately after its transfer.
  - Required: order ACK(3), DATA, ACK. Handshake never wins twice while data is eligible.
- Ineligible data:
  - Stimulus: data_req with data_len=10, buffer_occupancy=9.
  - Required: no grant and tx_packet=0. Raising occupancy to 10 → grant and command.
  - Separately, data_len=65 → data_grant and err in the same cycle, busy stays 0.
- Start timeout:
  - Stimulus: tx_transfer_active never rises.
  - Required: err pulse exactly START_TIMEOUT cycles after WAIT_START entry; toggle unchanged; return to IDLE.
- TX error:
  - Stimulus: tx_error pulses mid-ACTIVE, then active falls.
  - Required: err pulse (no done); toggle unchanged.
  - Separately, toggle_clr coinciding with DONE of a good data packet → data_toggle=0.
- Reset mid-transfer:
  - Stimulus: rst asserted during ACTIVE.
  - Required: all outputs 0 asynchronously. After release, a new hs_req is served normally with toggle=0.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared encodings for the USB TX scheduler: command codes, handshake PIDs,
// arbiter select values and the control FSM state type.
package usb_tx_pkg;

    localparam logic [3:0] TXP_IDLE  = 4'd0;
    localparam logic [3:0] TXP_DATA0 = 4'd1;
    localparam logic [3:0] TXP_DATA1 = 4'd2;
    localparam logic [3:0] TXP_ACK   = 4'd3;
    localparam logic [3:0] TXP_NAK   = 4'd4;
    localparam logic [3:0] TXP_STALL = 4'd5;

    localparam logic [1:0] HS_ACK   = 2'd0;
    localparam logic [1:0] HS_NAK   = 2'd1;
    localparam logic [1:0] HS_STALL = 2'd2;
    localparam logic [1:0] HS_RSVD  = 2'd3;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_HS   = 2'd1;
    localparam logic [1:0] SEL_DATA = 2'd2;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_START = 3'd2,
        ACTIVE     = 3'd3,
        DONE       = 3'd4
    } state_t;

    // The reserved PID falls through to NAK.
    function automatic logic [3:0] hs_code(input logic [1:0] pid);
        logic [3:0] code;
        case (pid)
            HS_ACK:   code = TXP_ACK;
            HS_STALL: code = TXP_STALL;
            default:  code = TXP_NAK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/usb_tx_arb.sv
// Request eligibility and handshake/data arbitration with a one-win fairness
// flag so data cannot be starved by back-to-back handshakes.
module usb_tx_arb #(
    parameter int MAX_LEN = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hs_req_i,
    input  logic       data_req_i,
    input  logic [6:0] data_len_i,
    input  logic [6:0] buffer_occupancy_i,
    input  logic       arb_en_i,
    output logic [1:0] sel_o,
    output logic       data_oversize_o
);
    import usb_tx_pkg::*;

    localparam logic [7:0] MAX_LEN_W = 8'(MAX_LEN);

    logic fair_q;
    logic fair_d;
    logic data_elig;

    always_comb begin
        data_oversize_o = ({1'b0, data_len_i} > MAX_LEN_W);
        data_elig       = data_req_i && !data_oversize_o
                          && (buffer_occupancy_i >= data_len_i);

        sel_o = SEL_NONE;
        if (hs_req_i && data_elig) begin
            sel_o = fair_q ? SEL_DATA : SEL_HS;
        end else if (hs_req_i) begin
            sel_o = SEL_HS;
        end else if (data_elig) begin
            sel_o = SEL_DATA;
        end

        // A contested win by hs sets the flag; the next contested win goes to data and clears it.
        fair_d = fair_q;
        if (arb_en_i && hs_req_i && data_elig) begin
            fair_d = !fair_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fair_q <= 1'b0;
        end else begin
            fair_q <= fair_d;
        end
    end

endmodule

// File: rtl/usb_tx_sched.sv
// USB TX scheduler: issues one tx_packet command at a time, follows it through
// the TX datapath handshake and reports done/err while keeping the data toggle.
module usb_tx_sched #(
    parameter int START_TIMEOUT = 16,
    parameter int MAX_LEN       = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs_req,
    input  logic [1:0] hs_pid,
    output logic       hs_grant,
    input  logic       data_req,
    input  logic [6:0] data_len,
    output logic       data_grant,
    input  logic [6:0] buffer_occupancy,
    input  logic       toggle_clr,
    output logic [3:0] tx_packet,
    input  logic       tx_transfer_active,
    input  logic       tx_error,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       data_toggle
);
    import usb_tx_pkg::*;

    localparam int              CNT_W    = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic             is_data_q, is_data_d;
    logic [3:0]       hs_code_q, hs_code_d;
    logic             toggle_q, toggle_d;
    logic [3:0]       tx_packet_q, tx_packet_d;
    logic             hs_grant_q, hs_grant_d;
    logic             data_grant_q, data_grant_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [1:0]       sel;
    logic             data_oversize;
    logic             arb_en;

    assign arb_en = (state_q == IDLE);

    usb_tx_arb #(
        .MAX_LEN(MAX_LEN)
    ) u_arb (
        .clk_i              (clk),
        .rst_i              (rst),
        .hs_req_i           (hs_req),
        .data_req_i         (data_req),
        .data_len_i         (data_len),
        .buffer_occupancy_i (buffer_occupancy),
        .arb_en_i           (arb_en),
        .sel_o              (sel),
        .data_oversize_o    (data_oversize)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sticky_d     = sticky_q;
        is_data_d    = is_data_q;
        hs_code_d    = hs_code_q;
        toggle_d     = toggle_q;
        tx_packet_d  = TXP_IDLE;
        hs_grant_d   = 1'b0;
        data_grant_d = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel == SEL_HS) begin
                    state_d    = ISSUE;
                    hs_grant_d = 1'b1;
                    is_data_d  = 1'b0;
                    hs_code_d  = hs_code(hs_pid);
                end else if (sel == SEL_DATA) begin
                    state_d      = ISSUE;
                    data_grant_d = 1'b1;
                    is_data_d    = 1'b1;
                end else if (data_req && data_oversize && !data_grant_q) begin
                    // Reject oversize payloads; guard keeps the level request from double-pulsing.
                    data_grant_d = 1'b1;
                    err_d        = 1'b1;
                end
            end
            ISSUE: begin
                if (is_data_q) begin
                    tx_packet_d = toggle_q ? TXP_DATA1 : TXP_DATA0;
                end else begin
                    tx_packet_d = hs_code_q;
                end
                cnt_d    = '0;
                sticky_d = 1'b0;
                state_d  = WAIT_START;
            end
            WAIT_START: begin
                if (tx_transfer_active) begin
                    state_d = ACTIVE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACTIVE: begin
                sticky_d = sticky_q | tx_error;
                if (!tx_transfer_active) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (sticky_q) begin
                    err_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                    if (is_data_q) begin
                        toggle_d = !toggle_q;
                    end
                end
                sticky_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (toggle_clr) begin
            toggle_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sticky_q     <= 1'b0;
            is_data_q    <= 1'b0;
            hs_code_q    <= TXP_IDLE;
            toggle_q     <= 1'b0;
            tx_packet_q  <= TXP_IDLE;
            hs_grant_q   <= 1'b0;
            data_grant_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sticky_q     <= sticky_d;
            is_data_q    <= is_data_d;
            hs_code_q    <= hs_code_d;
            toggle_q     <= toggle_d;
            tx_packet_q  <= tx_packet_d;
            hs_grant_q   <= hs_grant_d;
            data_grant_q <= data_grant_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign tx_packet   = tx_packet_q;
    assign hs_grant    = hs_grant_q;
    assign data_grant  = data_grant_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign data_toggle = toggle_q;

endmodule

// File: tb/tb_usb_tx_sched.sv
// Scoreboard bench for usb_tx_sched: a transaction-level model predicts the
// event stream (grants, commands, done/err with toggle), a monitor checks it.
module tb_usb_tx_sched;

    localparam int K_HSG  = 0;
    localparam int K_DG   = 1;
    localparam int K_CMD  = 2;
    localparam int K_DONE = 3;
    localparam int K_ERR  = 4;
    localparam int TOUT   = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       hs_req;
    logic [1:0] hs_pid;
    logic       hs_grant;
    logic       data_req;
    logic [6:0] data_len;
    logic       data_grant;
    logic [6:0] buffer_occupancy;
    logic       toggle_clr;
    logic [3:0] tx_packet;
    logic       tx_transfer_active;
    logic       tx_error;
    logic       busy;
    logic       done;
    logic       err;
    logic       data_toggle;

    usb_tx_sched #(
        .START_TIMEOUT(TOUT),
        .MAX_LEN(64)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .hs_req             (hs_req),
        .hs_pid             (hs_pid),
        .hs_grant           (hs_grant),
        .data_req           (data_req),
        .data_len           (data_len),
        .data_grant         (data_grant),
        .buffer_occupancy   (buffer_occupancy),
        .toggle_clr         (toggle_clr),
        .tx_packet          (tx_packet),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error),
        .busy               (busy),
        .done               (done),
        .err                (err),
        .data_toggle        (data_toggle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t exq[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  m_toggle = 0;
    int  m_fair = 0;
    int  txs = 0;
    int  txc = 0;
    int  tx_delay = 3;
    int  tx_hold = 40;
    int  tx_err_at = -1;
    int  hs_rearm = 0;
    bit  tx_never = 0;
    bit  clr_on_done = 0;
    bit  clr_arm = 0;
    bit  rearm_now = 0;

    function automatic string kname(input int k);
        case (k)
            K_HSG:   return "hs_grant";
            K_DG:    return "data_grant";
            K_CMD:   return "tx_packet";
            K_DONE:  return "done";
            default: return "err";
        endcase
    endfunction

    function automatic int hs_cmd(input int pid);
        case (pid)
            0:       return 3;
            2:       return 5;
            default: return 4;
        endcase
    endfunction

    task automatic push(input int k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exq.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, need %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_ev(input int kind, input int val);
        ev_t e;
        total++;
        if (exq.size() == 0) begin
            bad++;
            $display("FAIL %s: got value %0d at cycle %0d, no event expected", kname(kind), val, cyc);
        end else begin
            e = exq.pop_front();
            if (e.kind != kind || e.val != val) begin
                bad++;
                $display("FAIL event_order: got %s=%0d, need %s=%0d (cycle %0d)",
                         kname(kind), val, kname(e.kind), e.val, cyc);
            end
        end
    endtask

    // Model of one served request: grant, command code, then outcome with toggle.
    task automatic exp_serve(input int is_data, input int pid, input int fail, input int clr);
        push(is_data != 0 ? K_DG : K_HSG, 0);
        push(K_CMD, is_data != 0 ? (m_toggle != 0 ? 2 : 1) : hs_cmd(pid));
        if (fail != 0) begin
            push(K_ERR, m_toggle);
        end else begin
            if (clr != 0) m_toggle = 0;
            else if (is_data != 0) m_toggle = 1 - m_toggle;
            push(K_DONE, m_toggle);
        end
    endtask

    // Service order for hs_n handshakes and an optional eligible data request.
    task automatic exp_sched(input int hs_n, input int pid, input int dat, input int fail);
        int h = hs_n;
        int d = dat;
        while (h > 0 || d != 0) begin
            if (h > 0 && d != 0 && m_fair != 0) begin
                m_fair = 0;
                exp_serve(1, pid, fail, 0);
                d = 0;
            end else if (h > 0) begin
                if (d != 0) m_fair = 1;
                exp_serve(0, pid, fail, 0);
                h--;
            end else begin
                exp_serve(1, pid, fail, 0);
                d = 0;
            end
        end
    endtask

    // One clock: requester behaviour, toggle_clr pulse and the TX datapath model.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rearm_now) begin
            hs_req    = 1'b1;
            rearm_now = 1'b0;
        end
        if (hs_grant) begin
            hs_req = 1'b0;
            if (hs_rearm > 0) begin
                hs_rearm--;
                rearm_now = 1'b1;
            end
        end
        if (data_grant) data_req = 1'b0;
        if (clr_arm) begin
            toggle_clr = 1'b1;
            clr_arm    = 1'b0;
        end else begin
            toggle_clr = 1'b0;
        end
        case (txs)
            0: if (tx_packet != 4'd0 && !tx_never) begin
                txs = 1;
                txc = tx_delay;
            end
            1: begin
                txc--;
                if (txc == 0) begin
                    tx_transfer_active = 1'b1;
                    txs = 2;
                    txc = tx_hold;
                end
            end
            default: begin
                tx_error = (txc == tx_err_at);
                txc--;
                if (txc == 0) begin
                    tx_transfer_active = 1'b0;
                    tx_error = 1'b0;
                    txs = 0;
                    if (clr_on_done) clr_arm = 1'b1;
                end
            end
        endcase
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((exq.size() != 0 || busy || txs != 0 || hs_req || data_req || rearm_now || hs_rearm > 0)
               && n < limit) begin
            tick();
            n++;
        end
        total++;
        if (n >= limit) begin
            bad++;
            $display("FAIL drain: %0d events still outstanding after %0d cycles, need 0", exq.size(), limit);
            exq.delete();
            hs_req = 1'b0;
            data_req = 1'b0;
            hs_rearm = 0;
            rearm_now = 1'b0;
        end
        repeat (2) tick();
    endtask

    task automatic run_req(input int hs_n, input int pid, input int dat,
                           input int len, input int occ, input int fail);
        hs_pid = 2'(pid);
        data_len = 7'(len);
        buffer_occupancy = 7'(occ);
        exp_sched(hs_n, pid, dat, fail);
        hs_rearm = (hs_n > 1) ? hs_n - 1 : 0;
        if (hs_n > 0) hs_req = 1'b1;
        if (dat != 0) data_req = 1'b1;
        drain(600);
    endtask

    initial begin
        int n;
        int t0;
        int seen;
        rst = 1'b1;
        hs_req = 1'b0;
        hs_pid = 2'd0;
        data_req = 1'b0;
        data_len = 7'd0;
        buffer_occupancy = 7'd0;
        toggle_clr = 1'b0;
        tx_transfer_active = 1'b0;
        tx_error = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (hs_grant)          check_ev(K_HSG, 0);
                    if (data_grant)        check_ev(K_DG, 0);
                    if (tx_packet != 4'd0) check_ev(K_CMD, int'(tx_packet));
                    if (done)              check_ev(K_DONE, int'(data_toggle));
                    if (err)               check_ev(K_ERR, int'(data_toggle));
                end
            end
            begin
                #1000000;
                $display("FAIL watchdog: simulation still running at %0t, need finish", $time);
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (3) tick();
        chk("reset_outputs", int'({hs_grant, data_grant, tx_packet, busy, done, err, data_toggle}), 0);
        rst = 1'b0;
        repeat (2) tick();

        // Data packet, 2-cycle request-to-command latency, then DATA1 on repeat.
        tx_delay = 3; tx_hold = 40; tx_err_at = -1;
        data_len = 7'd8; buffer_occupancy = 7'd8;
        exp_sched(0, 0, 1, 0);
        data_req = 1'b1;
        tick();
        chk("grant_latency", int'(data_grant), 1);
        tick();
        chk("cmd_latency", int'(tx_packet), 1);
        drain(200);
        chk("toggle_after_data0", int'(data_toggle), 1);
        run_req(0, 0, 1, 8, 8, 0);
        chk("toggle_after_data1", int'(data_toggle), 0);

        // Simultaneous requests with hs reasserted: ACK, DATA, ACK.
        tx_hold = 6;
        run_req(2, 0, 1, 4, 20, 0);

        // Ineligible data waits until occupancy catches up.
        data_len = 7'd10; buffer_occupancy = 7'd9; data_req = 1'b1;
        seen = 0;
        repeat (8) begin
            tick();
            seen = seen | int'(busy) | int'(tx_packet != 4'd0);
        end
        chk("ineligible_idle", seen, 0);
        exp_sched(0, 0, 1, 0);
        buffer_occupancy = 7'd10;
        drain(200);

        // Oversize payload: grant and err together, FSM stays idle.
        data_len = 7'd65; buffer_occupancy = 7'd127;
        push(K_DG, 0);
        push(K_ERR, m_toggle);
        data_req = 1'b1;
        tick();
        chk("oversize_grant_err", int'({data_grant, err}), 3);
        seen = int'(busy);
        repeat (4) begin
            tick();
            seen = seen | int'(busy);
        end
        chk("oversize_busy", seen, 0);
        drain(50);

        // Start timeout on a zero-length data packet.
        tx_never = 1'b1;
        data_len = 7'd0; buffer_occupancy = 7'd0;
        push(K_DG, 0);
        push(K_CMD, m_toggle != 0 ? 2 : 1);
        push(K_ERR, m_toggle);
        data_req = 1'b1;
        n = 0;
        while (tx_packet == 4'd0 && n < 10) begin tick(); n++; end
        t0 = cyc;
        n = 0;
        while (!err && n < 40) begin tick(); n++; end
        chk("timeout_cycles", cyc - t0, TOUT);
        tx_never = 1'b0;
        drain(100);

        // TX error during ACTIVE for a NAK and for a data packet.
        tx_hold = 6; tx_err_at = 3;
        run_req(1, 1, 0, 0, 0, 1);
        run_req(0, 0, 1, 5, 9, 1);
        chk("toggle_after_error", int'(data_toggle), m_toggle);
        tx_err_at = -1;

        // toggle_clr coinciding with the DONE of a good data packet.
        clr_on_done = 1'b1;
        data_len = 7'd3; buffer_occupancy = 7'd3;
        exp_serve(1, 0, 0, 1);
        data_req = 1'b1;
        drain(200);
        clr_on_done = 1'b0;
        chk("toggle_clr_wins", int'(data_toggle), 0);

        // Randomised traffic.
        for (int i = 0; i < 40; i++) begin
            int kind = int'($urandom_range(0, 3));
            int len  = int'($urandom_range(0, 64));
            int occ  = int'($urandom_range(len, 127));
            int pid  = int'($urandom_range(0, 3));
            tx_delay = int'($urandom_range(1, 5));
            tx_hold  = int'($urandom_range(3, 12));
            tx_err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, tx_hold)) : -1;
            if (kind == 3) begin
                data_len = 7'($urandom_range(65, 127));
                buffer_occupancy = 7'd127;
                push(K_DG, 0);
                push(K_ERR, m_toggle);
                data_req = 1'b1;
                drain(50);
            end else begin
                run_req(kind != 1 ? 1 : 0, pid, kind != 0 ? 1 : 0, len, occ,
                        tx_err_at >= 0 ? 1 : 0);
            end
        end
        tx_err_at = -1;

        // Reset during ACTIVE, then a fresh handshake with toggle back at 0.
        tx_delay = 2; tx_hold = 6;
        if (m_toggle == 0) run_req(0, 0, 1, 2, 2, 0);
        chk("toggle_before_reset", int'(data_toggle), 1);
        tx_hold = 40;
        hs_pid = 2'd0;
        push(K_HSG, 0);
        push(K_CMD, 3);
        hs_req = 1'b1;
        n = 0;
        while (!tx_transfer_active && n < 20) begin tick(); n++; end
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("reset_async_outputs", int'({hs_grant, data_grant, tx_packet, busy, done, err, data_toggle}), 0);
        chk("reset_pending_events", exq.size(), 0);
        exq.delete();
        txs = 0;
        tx_transfer_active = 1'b0;
        tx_error = 1'b0;
        hs_req = 1'b0;
        m_toggle = 0;
        m_fair = 0;
        repeat (2) tick();
        rst = 1'b0;
        tx_hold = 5;
        run_req(1, 0, 0, 0, 0, 0);
        chk("toggle_after_reset", int'(data_toggle), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
